timer_counter_ctrl: RTL and testbench

TIMER_COUNTER_CTRL -- requirements
Module: timer_counter_ctrl

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/timer_prescaler.sv | 33 +++
 rtl/timer_counter_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_counter_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, TCR field positions, data width and CKS encodings for the timer.
// Revision 1.0
`default_nettype none

package timer_pkg;

  localparam int DATA_W = 8;

  localparam int TCR_LOAD_BIT    = 7;
  localparam int TCR_ONESHOT_BIT = 6;
  localparam int TCR_DOWN_BIT    = 5;
  localparam int TCR_EN_BIT      = 4;

  localparam logic [1:0] CKS_DIV2  = 2'b00;
  localparam logic [1:0] CKS_DIV4  = 2'b01;
  localparam logic [1:0] CKS_DIV8  = 2'b10;
  localparam logic [1:0] CKS_DIV16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Terminal prescaler value for a clock select: 2^(cks+1)-1.
  function automatic logic [3:0] cks_terminal(input logic [1:0] cks);
    logic [3:0] term;
    term = 4'd1;
    case (cks)
      CKS_DIV2:  term = 4'd1;
      CKS_DIV4:  term = 4'd3;
      CKS_DIV8:  term = 4'd7;
      CKS_DIV16: term = 4'd15;
      default:   term = 4'd1;
    endcase
    return term;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// timer_prescaler: 4-bit prescaler with selectable divide-by-2/4/8/16 tick.
// Revision 1.0
`default_nettype none

module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [3:0] prescale;

  // A >= compare lets a mid-run CKS reduction tick at once instead of wrapping.
  assign tick = enable && (prescale >= cks_terminal(cks));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 4'd0;
    end else if (clear || tick) begin
      prescale <= 4'd0;
    end else if (enable) begin
      prescale <= prescale + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_counter_ctrl.sv
// timer_counter_ctrl: 8-bit up/down timer with reload, prescaler and sticky wrap flags.
// Revision 1.0 -- optional one-shot halt enabled by TIMER_CTRL_ONESHOT_EN.
`default_nettype none

module timer_counter_ctrl
  import timer_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [DATA_W-1:0] TDR,
  input  logic [7:0]        TCR,
  input  logic              OVF_RESET_SIGNAL,
  input  logic              UNDF_RESET_SIGNAL,
  output logic [DATA_W-1:0] TCNT,
  output logic [1:0]        CL_IN,
  output logic              RUNNING
);

  state_t state, state_nxt;
  logic   load_q;
  logic   load_edge;
  logic   enable;
  logic   down;
  logic   tick;
  logic   step;
  logic   at_max;
  logic   at_min;
  logic   ovf_set;
  logic   undf_set;
  logic   oneshot_stop;

  assign load_edge = TCR[TCR_LOAD_BIT] && !load_q;
  assign enable    = TCR[TCR_EN_BIT];
  assign down      = TCR[TCR_DOWN_BIT];
  assign at_max    = (TCNT == {DATA_W{1'b1}});
  assign at_min    = (TCNT == {DATA_W{1'b0}});

  // A pending reload or a disable both pre-empt the count step.
  assign step     = tick && !load_edge && enable;
  assign ovf_set  = step && !down && at_max;
  assign undf_set = step && down && at_min;

`ifdef TIMER_CTRL_ONESHOT_EN
  assign oneshot_stop = TCR[TCR_ONESHOT_BIT] && (ovf_set || undf_set);
  logic unused_tcr;
  assign unused_tcr = ^TCR[3:2];
`else
  assign oneshot_stop = 1'b0;
  logic unused_tcr;
  assign unused_tcr = ^{TCR[TCR_ONESHOT_BIT], TCR[3:2]};
`endif

  timer_prescaler u_prescaler (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .cks    (TCR[1:0]),
    .tick   (tick)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= ST_IDLE;
      load_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= TCR[TCR_LOAD_BIT];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (load_edge)   state_nxt = ST_LOAD;
        else if (enable) state_nxt = ST_RUN;
        else             state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (load_edge)         state_nxt = ST_LOAD;
        else if (!enable)      state_nxt = ST_IDLE;
        else if (oneshot_stop) state_nxt = ST_HALT;
        else                   state_nxt = ST_RUN;
      end
`ifdef TIMER_CTRL_ONESHOT_EN
      ST_HALT: begin
        if (load_edge)    state_nxt = ST_LOAD;
        else if (!enable) state_nxt = ST_IDLE;
        else              state_nxt = ST_HALT;
      end
`endif
      default: begin
        if (load_edge)   state_nxt = ST_LOAD;
        else if (enable) state_nxt = ST_RUN;
        else             state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      TCNT <= '0;
    end else if (state == ST_LOAD) begin
      TCNT <= TDR;
    end else if (step) begin
      TCNT <= down ? TCNT - 1'b1 : TCNT + 1'b1;
    end
  end

  // A new wrap wins over a simultaneous clear so no event is lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      CL_IN <= 2'b00;
    end else begin
      CL_IN[0] <= ovf_set  || (CL_IN[0] && !OVF_RESET_SIGNAL);
      CL_IN[1] <= undf_set || (CL_IN[1] && !UNDF_RESET_SIGNAL);
    end
  end

  assign RUNNING = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_timer_counter_ctrl.sv
// tb_timer_counter_ctrl: directed vector table plus hand-written sequences for timer_counter_ctrl.
// Revision 1.0
`default_nettype none

module tb_timer_counter_ctrl;

  logic       PCLK;
  logic       PRESETn;
  logic [7:0] TDR;
  logic [7:0] TCR;
  logic       OVF_RESET_SIGNAL;
  logic       UNDF_RESET_SIGNAL;
  logic [7:0] TCNT;
  logic [1:0] CL_IN;
  logic       RUNNING;

  int checks = 0;
  int errors = 0;

  timer_counter_ctrl dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .TDR               (TDR),
    .TCR               (TCR),
    .OVF_RESET_SIGNAL  (OVF_RESET_SIGNAL),
    .UNDF_RESET_SIGNAL (UNDF_RESET_SIGNAL),
    .TCNT              (TCNT),
    .CL_IN             (CL_IN),
    .RUNNING           (RUNNING)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] tdr;
    logic [7:0] tcr;
    logic       ovf_clr;
    logic       undf_clr;
    int         cycles;
    logic [7:0] exp_tcnt;
    logic [1:0] exp_cl;
    logic       exp_run;
    string      name;
  } vec_t;

  vec_t vec [16];

  task automatic wait_edges(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] e_tcnt,
                       input logic [1:0] e_cl, input logic e_run);
    checks++;
    if (TCNT !== e_tcnt) begin
      errors++;
      $display("FAIL %s TCNT got %h expected %h", name, TCNT, e_tcnt);
    end
    checks++;
    if (CL_IN !== e_cl) begin
      errors++;
      $display("FAIL %s CL_IN got %b expected %b", name, CL_IN, e_cl);
    end
    checks++;
    if (RUNNING !== e_run) begin
      errors++;
      $display("FAIL %s RUNNING got %b expected %b", name, RUNNING, e_run);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Up-count reload through overflow, flag clear, then down-count div16 through underflow.
    vec[0]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 1,  8'h00, 2'b00, 1'b0, "load_state"};
    vec[1]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 1,  8'hFD, 2'b00, 1'b1, "loaded_fd"};
    vec[2]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 2,  8'hFE, 2'b00, 1'b1, "up_fe"};
    vec[3]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 2,  8'hFF, 2'b00, 1'b1, "up_ff"};
    vec[4]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 2,  8'h00, 2'b01, 1'b1, "ovf_wrap"};
    vec[5]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 2,  8'h01, 2'b01, 1'b1, "ovf_sticky"};
    vec[6]  = '{8'hFD, 8'h90, 1'b1, 1'b0, 1,  8'h01, 2'b00, 1'b1, "ovf_clear"};
    vec[7]  = '{8'hFD, 8'h90, 1'b0, 1'b0, 1,  8'h02, 2'b00, 1'b1, "up_02"};
    vec[8]  = '{8'hFD, 8'h00, 1'b0, 1'b0, 1,  8'h02, 2'b00, 1'b0, "disable_idle"};
    vec[9]  = '{8'h01, 8'hB3, 1'b0, 1'b0, 1,  8'h02, 2'b00, 1'b0, "load_state2"};
    vec[10] = '{8'h01, 8'hB3, 1'b0, 1'b0, 1,  8'h01, 2'b00, 1'b1, "loaded_01"};
    vec[11] = '{8'h01, 8'hB3, 1'b0, 1'b0, 15, 8'h01, 2'b00, 1'b1, "div16_hold"};
    vec[12] = '{8'h01, 8'hB3, 1'b0, 1'b0, 1,  8'h00, 2'b00, 1'b1, "down_00"};
    vec[13] = '{8'h01, 8'hB3, 1'b0, 1'b0, 16, 8'hFF, 2'b10, 1'b1, "undf_wrap"};
    vec[14] = '{8'h01, 8'hB3, 1'b0, 1'b1, 1,  8'hFF, 2'b00, 1'b1, "undf_clear"};
    vec[15] = '{8'h01, 8'h00, 1'b0, 1'b0, 1,  8'hFF, 2'b00, 1'b0, "idle_again"};

    PRESETn = 1'b0;
    TDR = 8'h00;
    TCR = 8'h00;
    OVF_RESET_SIGNAL = 1'b0;
    UNDF_RESET_SIGNAL = 1'b0;
    wait_edges(2);
    check("reset", 8'h00, 2'b00, 1'b0);
    PRESETn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      TDR = vec[i].tdr;
      TCR = vec[i].tcr;
      OVF_RESET_SIGNAL = vec[i].ovf_clr;
      UNDF_RESET_SIGNAL = vec[i].undf_clr;
      wait_edges(vec[i].cycles);
      check(vec[i].name, vec[i].exp_tcnt, vec[i].exp_cl, vec[i].exp_run);
    end

    // New overflow coinciding with a clear keeps the flag; a lone clear drops it.
    TDR = 8'hFF;
    TCR = 8'h90;
    wait_edges(4);
    check("ovf_first", 8'h00, 2'b01, 1'b1);
    TCR = 8'h10;
    wait_edges(1);
    TCR = 8'h90;
    wait_edges(1);
    check("reload_in_run", 8'h00, 2'b01, 1'b0);
    wait_edges(2);
    check("reloaded_ff", 8'hFF, 2'b01, 1'b1);
    OVF_RESET_SIGNAL = 1'b1;
    wait_edges(1);
    check("ovf_set_wins", 8'h00, 2'b01, 1'b1);
    OVF_RESET_SIGNAL = 1'b0;
    wait_edges(1);
    OVF_RESET_SIGNAL = 1'b1;
    wait_edges(1);
    check("ovf_lone_clear", 8'h01, 2'b00, 1'b1);
    OVF_RESET_SIGNAL = 1'b0;

    // Asynchronous reset mid-count, then resume from zero with enable held.
    TCR = 8'h00;
    wait_edges(1);
    TDR = 8'h7E;
    TCR = 8'h90;
    wait_edges(4);
    TCR = 8'h10;
    check("count_7f", 8'h7F, 2'b00, 1'b1);
    PRESETn = 1'b0;
    #1;
    check("async_reset", 8'h00, 2'b00, 1'b0);
    wait_edges(2);
    PRESETn = 1'b1;
    wait_edges(1);
    check("resume_run", 8'h00, 2'b00, 1'b1);
    wait_edges(2);
    check("resume_01", 8'h01, 2'b00, 1'b1);

    // CKS drop from div16 with prescaler at 9 ticks on the next cycle.
    TCR = 8'h13;
    wait_edges(9);
    check("div16_pre9", 8'h01, 2'b00, 1'b1);
    TCR = 8'h10;
    wait_edges(1);
    check("cks_switch_tick", 8'h02, 2'b00, 1'b1);
    wait_edges(1);
    check("cks_switch_hold", 8'h02, 2'b00, 1'b1);
    wait_edges(1);
    check("cks_switch_next", 8'h03, 2'b00, 1'b1);

    // One-shot request on an overflow.
    TCR = 8'h00;
    wait_edges(1);
    TDR = 8'hFF;
    TCR = 8'hD0;
    wait_edges(2);
    check("oneshot_loaded", 8'hFF, 2'b00, 1'b1);
`ifdef TIMER_CTRL_ONESHOT_EN
    wait_edges(2);
    check("oneshot_wrap", 8'h00, 2'b01, 1'b0);
    wait_edges(50);
    check("oneshot_hold", 8'h00, 2'b01, 1'b0);
`else
    wait_edges(2);
    check("oneshot_ignored", 8'h00, 2'b01, 1'b1);
    wait_edges(2);
    check("oneshot_continue", 8'h01, 2'b01, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
